i2c_slave_regif: RTL
====================

Name: i2c_slave_regif

Overview:
- I2C target (slave) responder: the far end of our I2C master path.
- Lets an FPGA-internal register bank be written and read by an external or on-board I2C master, for example a controller driving our board the way our init sequencers drive the ADV7511.
- Decodes START/STOP, matches a 7-bit address, ACKs, and supports writes (pointer byte, then data bytes) and reads, both with auto-increment.
- Exposes a simple synchronous register-access port to the fabric.

Parameters:
- SLAVE_ADDR, 7'h39, 7-bit target address matched against the first byte after START/Sr.
- RA_BW, 4, register address width; the pointer wraps modulo 2^RA_BW.

Ports:
- clock  input  1  system clock; must be at least 16x the SCL frequency.
- reset  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock from the bus; no clock stretching.
- sda  inout  1  I2C data; driven only to 0, otherwise high-Z.
- driving_sda  output  1  high while this block pulls SDA low.
- busy  output  1  high from address match until STOP, NACKed read, or address mismatch.
- wr_en  output  1  one-cycle write strobe.
- wr_addr  output  RA_BW  write register address.
- wr_data  output  8  write data.
- rd_addr  output  RA_BW  current pointer, driven continuously.
- rd_data  input  8  register contents at rd_addr; valid one clock after rd_addr changes.

Behaviour:
- Reset (reset=0, asynchronous), applies even mid-transfer:
  - driving_sda=0 (SDA released), busy=0, wr_en=0, wr_addr=0, wr_data=0, pointer=0.
  - State IDLE, bit count 0, synchronizer flops = 1.
- Input sampling: SCL and SDA each pass through a 2-flop synchronizer plus 1 history flop.
  - scl_rise / scl_fall: edge detect on the synchronized SCL.
  - START: synchronized SDA falls while SCL is high.
  - STOP: synchronized SDA rises while SCL is high.
- Bit timing:
  - Bits are sampled on scl_rise.
  - SDA drive changes only on scl_fall, applied the cycle after scl_fall is detected.
  - Data is MSB first.
- Bus conditions override every state:
  - START (also repeated START) -> ADDR with bit count 0; driving_sda released.
  - STOP -> IDLE, busy=0, driving_sda released.
  - An incomplete byte is discarded and produces no wr_en.
- State machine:
  - IDLE: wait for START.
  - ADDR: shift 8 bits.
    - Upper 7 bits == SLAVE_ADDR -> ADDR_ACK, busy=1.
    - Otherwise -> IGNORE (never drive SDA until the next START or STOP).
  - ADDR_ACK:
    - Assert driving_sda on the scl_fall after bit 8; release on the next scl_fall.
    - R/W=0 -> PTR.
    - R/W=1 -> RDATA: load shift register from rd_data on the releasing scl_fall and drive the MSB.
  - PTR: 8 bits received -> pointer <= byte[RA_BW-1:0] (upper bits ignored) -> PTR_ACK (ACK as above) -> WDATA.
  - WDATA:
    - 8 bits received -> in the same cycle: wr_en=1, wr_addr=pointer, wr_data=byte.
    - Next cycle: pointer <= pointer+1 (wrap).
    - Then WDATA_ACK (ACK) -> WDATA.
  - RDATA:
    - Drive 0 for each 0 bit, release for each 1 bit, changing on scl_fall.
    - After bit 8's scl_fall, release SDA -> RACK.
  - RACK: sample the master ACK on scl_rise.
    - Pointer increments after every byte transmitted, in both cases.
    - ACK (0): on the next scl_fall, load rd_data (new pointer) and drive its MSB -> RDATA.
    - NACK (1): -> IGNORE with busy=0; never drive SDA again until START or STOP.
- Arbitration and collision: none. In RDATA the block does not check the bus value.
- Simultaneous events:
  - START or STOP wins over bit sampling in the same cycle.
  - wr_en is never issued on the cycle a STOP is detected.
- Latency: wr_en fires 3 clock cycles after the SCL rising edge of data bit 8 reaches the pin (2 synchronizer stages + 1 registered output).

Decomposition:
- Shared package i2c_pkg holds:
  - the state enum (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE);
  - BYTE_BITS=8;
  - the RW_READ/RW_WRITE constants.
- One natural sub-module, i2c_bus_monitor: synchronizers plus scl_rise, scl_fall, start_det and stop_det outputs. It is reusable by future bus sniffers.

Test Plan:
- Write burst: START, 0x72, 0x03, 0xA5, 0x5A, STOP.
  - Required: ACK on all 4 bytes.
  - wr_en pulses exactly twice: (addr 3, data A5), then (addr 4, data 5A).
  - busy drops after STOP.
- Read with wrap: START, 0x72, 0x0F, Sr, 0x73, then read 2 bytes (master ACK, then NACK), STOP; bench rd_data = {4'hC, rd_addr}.
  - Required: bytes read are 0xCF then 0xC0.
  - SDA released after the NACK; no wr_en during the read.
- Address mismatch: START, 0x50, 0x11, STOP.
  - Required: SDA never driven, busy stays 0, no wr_en.
  - A following valid write to register 0x02 is ACKed and strobed.
- Aborted byte: START, 0x72, 0x01, 4 data bits, STOP.
  - Required: no wr_en, state IDLE, pointer = 1.
- Async reset during RDATA while a 0 bit is being driven.
  - Required: driving_sda drops combinationally-fast (same cycle) with no clock edge.
  - All outputs return to their reset values.
  - A later transaction works normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register interface and its bus monitor.
// State encodings are plain constants so legacy tools and netlists see fixed codes.
package i2c_pkg;

   localparam int BYTE_BITS = 8;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;

   typedef logic [3:0] state_t;

   localparam state_t IDLE      = 4'd0;
   localparam state_t ADDR      = 4'd1;
   localparam state_t ADDR_ACK  = 4'd2;
   localparam state_t PTR       = 4'd3;
   localparam state_t PTR_ACK   = 4'd4;
   localparam state_t WDATA     = 4'd5;
   localparam state_t WDATA_ACK = 4'd6;
   localparam state_t RDATA     = 4'd7;
   localparam state_t RACK      = 4'd8;
   localparam state_t IGNORE    = 4'd9;

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into the clock domain and flags SCL edges plus START/STOP.
// Reusable by anything that only needs to observe the bus.
module i2c_bus_monitor (
   input  logic clock,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_bit
);

   logic [1:0] pins;
   logic [1:0] sync_s;
   logic [1:0] hist_s;

   assign pins = {sda, scl};

   // Bit 0 carries SCL, bit 1 carries SDA; both idle high on the bus.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_sync
         logic s1_reg;
         logic s2_reg;
         logic h_reg;

         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               s1_reg <= 1'b1;
               s2_reg <= 1'b1;
               h_reg  <= 1'b1;
            end else begin
               s1_reg <= pins[gi];
               s2_reg <= s1_reg;
               h_reg  <= s2_reg;
            end
         end

         assign sync_s[gi] = s2_reg;
         assign hist_s[gi] = h_reg;
      end
   endgenerate

   assign scl_rise  = sync_s[0] & ~hist_s[0];
   assign scl_fall  = ~sync_s[0] & hist_s[0];
   assign start_det = sync_s[0] & hist_s[0] & hist_s[1] & ~sync_s[1];
   assign stop_det  = sync_s[0] & hist_s[0] & ~hist_s[1] & sync_s[1];
   assign sda_bit   = sync_s[1];

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C target giving an external master pointer-based, auto-incrementing
// read/write access to a fabric register bank.
module i2c_slave_regif
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h39,
   parameter int         RA_BW      = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             scl,
   inout  wire              sda,
   output logic             driving_sda,
   output logic             busy,
   output logic             wr_en,
   output logic [RA_BW-1:0] wr_addr,
   output logic [7:0]       wr_data,
   output logic [RA_BW-1:0] rd_addr,
   input  logic [7:0]       rd_data
);

   localparam logic [3:0] LAST_BIT  = 4'(BYTE_BITS - 1);
   localparam logic [3:0] DONE_BITS = 4'(BYTE_BITS);

   logic scl_rise, scl_fall, start_det, stop_det, sda_bit;

   state_t           state_reg;
   logic [3:0]       bit_cnt_reg;
   logic [7:0]       shift_reg;
   logic [RA_BW-1:0] ptr_reg;
   logic             drive_reg, busy_reg, rw_reg, wr_en_reg;
   logic [RA_BW-1:0] wr_addr_reg;
   logic [7:0]       wr_data_reg;
   logic [7:0]       byte_in;

   i2c_bus_monitor u_mon (
      .clock     (clock),
      .reset     (reset),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_bit   (sda_bit)
   );

   assign byte_in = {shift_reg[6:0], sda_bit};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         ptr_reg     <= '0;
         drive_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         rw_reg      <= RW_WRITE;
         wr_en_reg   <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         wr_en_reg <= 1'b0;
         // Pointer steps the cycle after a write strobe so wr_addr holds the old value.
         if (wr_en_reg)
            ptr_reg <= ptr_reg + 1'b1;

         if (start_det) begin
            state_reg   <= ADDR;
            bit_cnt_reg <= '0;
            drive_reg   <= 1'b0;
         end else if (stop_det) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            drive_reg   <= 1'b0;
            busy_reg    <= 1'b0;
         end else begin
            case (state_reg)
               ADDR, PTR, WDATA: begin
                  if (scl_rise) begin
                     shift_reg   <= byte_in;
                     bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     if (bit_cnt_reg == LAST_BIT) begin
                        bit_cnt_reg <= '0;
                        case (state_reg)
                           ADDR: begin
                              if (byte_in[7:1] == SLAVE_ADDR) begin
                                 state_reg <= ADDR_ACK;
                                 busy_reg  <= 1'b1;
                                 rw_reg    <= byte_in[0];
                              end else begin
                                 state_reg <= IGNORE;
                                 busy_reg  <= 1'b0;
                              end
                           end
                           PTR: begin
                              ptr_reg   <= byte_in[RA_BW-1:0];
                              state_reg <= PTR_ACK;
                           end
                           default: begin
                              wr_en_reg   <= 1'b1;
                              wr_addr_reg <= ptr_reg;
                              wr_data_reg <= byte_in;
                              state_reg   <= WDATA_ACK;
                           end
                        endcase
                     end
                  end
               end
               // First SCL fall pulls SDA for the ACK slot, second one releases it.
               ADDR_ACK, PTR_ACK, WDATA_ACK: begin
                  if (scl_fall) begin
                     if (!drive_reg) begin
                        drive_reg <= 1'b1;
                     end else if (state_reg == ADDR_ACK && rw_reg == RW_READ) begin
                        shift_reg   <= rd_data;
                        drive_reg   <= ~rd_data[7];
                        bit_cnt_reg <= 4'd1;
                        state_reg   <= RDATA;
                     end else begin
                        drive_reg   <= 1'b0;
                        bit_cnt_reg <= '0;
                        state_reg   <= (state_reg == ADDR_ACK) ? PTR : WDATA;
                     end
                  end
               end
               RDATA: begin
                  if (scl_fall) begin
                     if (bit_cnt_reg == DONE_BITS) begin
                        drive_reg   <= 1'b0;
                        bit_cnt_reg <= '0;
                        state_reg   <= RACK;
                     end else begin
                        drive_reg   <= ~shift_reg[6];
                        shift_reg   <= {shift_reg[6:0], 1'b0};
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end
               // bit_cnt_reg doubles as the "master ACKed" flag while in RACK.
               RACK: begin
                  if (scl_rise) begin
                     ptr_reg <= ptr_reg + 1'b1;
                     if (sda_bit) begin
                        state_reg <= IGNORE;
                        busy_reg  <= 1'b0;
                     end else begin
                        bit_cnt_reg <= 4'd1;
                     end
                  end else if (scl_fall && bit_cnt_reg == 4'd1) begin
                     shift_reg   <= rd_data;
                     drive_reg   <= ~rd_data[7];
                     state_reg   <= RDATA;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign sda         = drive_reg ? 1'b0 : 1'bz;
   assign driving_sda = drive_reg;
   assign busy        = busy_reg;
   assign wr_en       = wr_en_reg;
   assign wr_addr     = wr_addr_reg;
   assign wr_data     = wr_data_reg;
   assign rd_addr     = ptr_reg;

endmodule
